// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file constants so that decode, the hazard unit and the register
// file agree on widths, special register indices and the stack-pointer reset value.
package regfile_scoreboard_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 2;

    // The stack starts just past the top of data memory.
    localparam logic [31:0] MEM_DEPTH   = 32'h0001_0000;
    localparam logic [31:0] SP_INIT_DEF = 32'h0100_0000 + MEM_DEPTH;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 reads zero, a same-cycle writeback is forwarded,
// otherwise the stored value is returned along with its scoreboard stall flag.
module regfile_read_port
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic [AW-1:0]               addr_i,
    input  logic                        we_i,
    input  logic [AW-1:0]               wr_addr_i,
    input  logic [XLEN-1:0]             wr_data_i,
    input  logic [NREGS-1:0][XLEN-1:0]  mem_i,
    input  logic [NREGS-1:0]            busy_i,
    output logic [XLEN-1:0]             data_o,
    output logic                        busy_o
);
    logic is_zero;
    logic wr_hit;

    assign is_zero = (addr_i == AW'(REG_ZERO));
    assign wr_hit  = we_i && (wr_addr_i == addr_i);

    always_comb begin
        data_o = mem_i[addr_i];
        if (is_zero)
            data_o = '0;
        else if (wr_hit)
            data_o = wr_data_i;
    end

    // A retiring producer is forwarded this cycle, so it must not stall the consumer.
    assign busy_o = busy_i[addr_i] && !wr_hit;
endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with x0 hardwired to zero, same-cycle
// write-to-read bypass and a per-register busy scoreboard for the hazard unit.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int              XLEN    = XLEN_DEF,
    parameter int              NREGS   = NREGS_DEF,
    parameter int              NRD     = NRD_DEF,
    parameter int              SP_IDX  = REG_SP,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
    localparam int             AW      = $clog2(NREGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    addr_rs,
    output logic [NRD*XLEN-1:0]  data_rs,
    output logic [NRD-1:0]       rs_busy,
    input  logic [AW-1:0]        addr_rd,
    input  logic [XLEN-1:0]      data_rd,
    input  logic                 write_enable,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 busy_any
);
    logic [NREGS-1:0][XLEN-1:0] mem_q;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic                       we_eff;

    // Writeback is ignored while reset is held, including for forwarding.
    assign we_eff = write_enable && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++)
                mem_q[r] <= (r == SP_IDX && r != REG_ZERO) ? SP_INIT : '0;
        end else if (we_eff && addr_rd != AW'(REG_ZERO)) begin
            mem_q[addr_rd] <= data_rd;
        end
    end

    // A newly issued producer supersedes one retiring in the same cycle.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            if (issue_valid && issue_rd == AW'(r))
                busy_d[r] = 1'b1;
            else if (we_eff && addr_rd == AW'(r))
                busy_d[r] = 1'b0;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_any = |busy_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rp (
            .addr_i    (addr_rs[i*AW +: AW]),
            .we_i      (we_eff),
            .wr_addr_i (addr_rd),
            .wr_data_i (data_rd),
            .mem_i     (mem_q),
            .busy_i    (busy_q),
            .data_o    (data_rs[i*XLEN +: XLEN]),
            .busy_o    (rs_busy[i])
        );
    end
endmodule
